sample_feeder: RTL and testbench

SAMPLE_FEEDER -- requirements
Module: sample_feeder

---
 rtl/sample_feeder_pkg.sv | 18 +
 rtl/sample_fifo.sv | 69 ++++++
 rtl/sample_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_sample_feeder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_feeder_pkg.sv
// Shared constants and types for the sample feeder.
// Holds the default sample width and divider, the lengths of the feed-start
// and feed-end pulses, and the controller state encoding.
package sample_feeder_pkg;

  localparam int INPUT_WIDTH_DEF = 16;
  localparam int CLK_DIV_DEF     = 8;
  localparam int RESET_CYCLES    = 4;
  localparam int COMPLETE_CYCLES = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESET    = 2'd1,
    ST_FEED     = 2'd2,
    ST_COMPLETE = 2'd3
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous single-clock FIFO buffering host samples for the feeder.
// Ports:
//   clk, reset_n      : clock, synchronous active-low reset
//   wr_en, wr_data    : write strobe and word (ignored when full)
//   rd_en, rd_data    : pop strobe and head word (rd_data valid when !empty)
//   full, empty       : occupancy flags
//   level             : number of stored words, 0..DEPTH
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_ok, rd_ok;

  assign full    = (count_q == FULL_LVL);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A word written into an empty FIFO only becomes visible next cycle,
  // because empty is derived from the registered count.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_ok && !rd_ok) count_d = count_q + (AW+1)'(1);
    else if (rd_ok && !wr_ok) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (reset_n && wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sample_feeder.sv
// Sample feeder: buffers host samples and replays a fixed-length feed to a
// channel at one sample per CLK_DIV clocks, with a divided sample clock.
// Ports:
//   clk, reset_n        : clock, synchronous active-low reset
//   start, feed_len     : begin a feed of feed_len samples (accepted in IDLE)
//   wr_en, wr_data      : host sample writes into the FIFO
//   wr_full, fill_level : FIFO status
//   clk_sample          : divided sample clock, rises mid-slot
//   sample_valid, data  : current sample and whether it is real
//   feed_reset          : pulse at start of a feed
//   feed_complete       : pulse at end of a feed
//   busy                : controller not idle
//   underrun            : sticky, a sample slot found the FIFO empty
module sample_feeder
  import sample_feeder_pkg::*;
#(
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int DEPTH       = 16,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int LEN_WIDTH   = 20,
  localparam int LW         = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   feed_len,
  input  logic                   wr_en,
  input  logic [INPUT_WIDTH-1:0] wr_data,
  output logic                   wr_full,
  output logic [LW-1:0]          fill_level,
  output logic                   clk_sample,
  output logic                   sample_valid,
  output logic [INPUT_WIDTH-1:0] data,
  output logic                   feed_reset,
  output logic                   feed_complete,
  output logic                   busy,
  output logic                   underrun
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PH_W  = 3;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RESET_CYCLES - 1);
  localparam logic [PH_W-1:0]  CMP_LAST = PH_W'(COMPLETE_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [PH_W-1:0]        phase_q, phase_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
  logic                   clk_sample_q, clk_sample_d;
  logic                   sample_valid_q, sample_valid_d;
  logic [INPUT_WIDTH-1:0] data_q, data_d;
  logic                   feed_reset_q, feed_reset_d;
  logic                   feed_complete_q, feed_complete_d;
  logic                   busy_q, busy_d;
  logic                   underrun_q, underrun_d;

  logic                   slot;
  logic                   pop;
  logic                   fifo_empty;
  logic [INPUT_WIDTH-1:0] fifo_rd_data;

  sample_fifo #(
    .WIDTH(INPUT_WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (wr_full),
    .empty  (fifo_empty),
    .level  (fill_level)
  );

  // Outputs are computed from the next divider value so that each output
  // register lines up with div_q: data changes as div_q enters 0 and
  // clk_sample is high while div_q is in the upper half of the period.
  always_comb begin
    state_d         = state_q;
    phase_d         = phase_q;
    div_d           = div_q;
    len_d           = len_q;
    cnt_d           = cnt_q;
    clk_sample_d    = 1'b0;
    sample_valid_d  = sample_valid_q;
    data_d          = data_q;
    feed_reset_d    = 1'b0;
    feed_complete_d = 1'b0;
    underrun_d      = underrun_q;
    slot            = 1'b0;
    pop             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d        = ST_RESET;
          phase_d        = '0;
          len_d          = feed_len;
          cnt_d          = '0;
          underrun_d     = 1'b0;
          sample_valid_d = 1'b0;
          feed_reset_d   = 1'b1;
        end
      end
      ST_RESET: begin
        feed_reset_d = 1'b1;
        phase_d      = phase_q + PH_W'(1);
        if (phase_q == RST_LAST) begin
          feed_reset_d = 1'b0;
          phase_d      = '0;
          div_d        = '0;
          if (len_q == '0) begin
            state_d         = ST_COMPLETE;
            feed_complete_d = 1'b1;
          end else begin
            state_d = ST_FEED;
            slot    = 1'b1;
          end
        end
      end
      ST_FEED: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (cnt_q == len_q) begin
            state_d         = ST_COMPLETE;
            phase_d         = '0;
            sample_valid_d  = 1'b0;
            feed_complete_d = 1'b1;
          end else begin
            slot = 1'b1;
          end
        end else begin
          div_d        = div_q + DIV_W'(1);
          clk_sample_d = (div_d >= DIV_HALF);
        end
      end
      ST_COMPLETE: begin
        feed_complete_d = 1'b1;
        phase_d         = phase_q + PH_W'(1);
        if (phase_q == CMP_LAST) begin
          feed_complete_d = 1'b0;
          phase_d         = '0;
          state_d         = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Start of a sample slot: take the FIFO head, or flag an underrun and
    // hold the previous data.
    if (slot) begin
      if (!fifo_empty) begin
        pop            = 1'b1;
        data_d         = fifo_rd_data;
        sample_valid_d = 1'b1;
        cnt_d          = cnt_q + LEN_WIDTH'(1);
      end else begin
        sample_valid_d = 1'b0;
        underrun_d     = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      phase_q         <= '0;
      div_q           <= '0;
      len_q           <= '0;
      cnt_q           <= '0;
      clk_sample_q    <= 1'b0;
      sample_valid_q  <= 1'b0;
      data_q          <= '0;
      feed_reset_q    <= 1'b0;
      feed_complete_q <= 1'b0;
      busy_q          <= 1'b0;
      underrun_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      phase_q         <= phase_d;
      div_q           <= div_d;
      len_q           <= len_d;
      cnt_q           <= cnt_d;
      clk_sample_q    <= clk_sample_d;
      sample_valid_q  <= sample_valid_d;
      data_q          <= data_d;
      feed_reset_q    <= feed_reset_d;
      feed_complete_q <= feed_complete_d;
      busy_q          <= busy_d;
      underrun_q      <= underrun_d;
    end
  end

  assign clk_sample    = clk_sample_q;
  assign sample_valid  = sample_valid_q;
  assign data          = data_q;
  assign feed_reset    = feed_reset_q;
  assign feed_complete = feed_complete_q;
  assign busy          = busy_q;
  assign underrun      = underrun_q;

endmodule

// File: tb/tb_sample_feeder.sv
module tb_sample_feeder;

  localparam int W  = 16;
  localparam int D  = 16;
  localparam int CD = 8;
  localparam int LW = 20;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] feed_len = '0;
  logic          wr_en = 1'b0;
  logic [W-1:0]  wr_data = '0;
  logic          wr_full;
  logic [4:0]    fill_level;
  logic          clk_sample;
  logic          sample_valid;
  logic [W-1:0]  data;
  logic          feed_reset;
  logic          feed_complete;
  logic          busy;
  logic          underrun;

  sample_feeder #(
    .INPUT_WIDTH(W),
    .DEPTH      (D),
    .CLK_DIV    (CD),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .feed_len     (feed_len),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .wr_full      (wr_full),
    .fill_level   (fill_level),
    .clk_sample   (clk_sample),
    .sample_valid (sample_valid),
    .data         (data),
    .feed_reset   (feed_reset),
    .feed_complete(feed_complete),
    .busy         (busy),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] sb[$];

  // monitor state
  int cyc = 0, rises = 0, inv_slots = 0, fr_pulses = 0, fc_pulses = 0;
  int fr_w = 0, fc_w = 0, last_rise = 0, rises_in_feed = 0;
  logic prev_clk = 1'b0, prev_fr = 1'b0, prev_fc = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Scoreboard monitor: every rising edge of clk_sample with sample_valid
  // must present the oldest outstanding expected word.
  initial begin
    logic [W-1:0] exp_w;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (clk_sample && !prev_clk) begin
          if (rises_in_feed > 0) check("rise_spacing", cyc - last_rise, CD);
          last_rise = cyc;
          rises_in_feed++;
          if (sample_valid) begin
            rises++;
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL sample_unexpected: got %0d expected none", data);
            end else begin
              exp_w = sb.pop_front();
              check("sample_data", data, exp_w);
            end
          end else begin
            inv_slots++;
          end
        end
        if (feed_reset) begin
          fr_w++;
          rises_in_feed = 0;
        end else if (prev_fr) begin
          fr_pulses++;
          check("feed_reset_width", fr_w, 4);
          fr_w = 0;
        end
        if (feed_complete) fc_w++;
        else if (prev_fc) begin
          fc_pulses++;
          check("feed_complete_width", fc_w, 4);
          fc_w = 0;
        end
      end else begin
        fr_w = 0;
        fc_w = 0;
        rises_in_feed = 0;
      end
      prev_clk = clk_sample;
      prev_fr  = feed_reset;
      prev_fc  = feed_complete;
    end
  end

  task automatic wr(input logic [W-1:0] v);
    wr_en = 1'b1;
    wr_data = v;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [LW-1:0] l);
    start = 1'b1;
    feed_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (!busy && n < 20) begin @(negedge clk); n++; end
    check({nm, "_busy_seen"}, busy, 1);
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    check({nm, "_idle"}, busy, 0);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_clk_sample"}, clk_sample, 0);
    check({nm, "_sample_valid"}, sample_valid, 0);
    check({nm, "_data"}, data, 0);
    check({nm, "_feed_reset"}, feed_reset, 0);
    check({nm, "_feed_complete"}, feed_complete, 0);
    check({nm, "_busy"}, busy, 0);
    check({nm, "_underrun"}, underrun, 0);
    check({nm, "_wr_full"}, wr_full, 0);
    check({nm, "_fill_level"}, fill_level, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, i0, fr0, fc0, n;

    // reset state
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // A: five samples in order, no underrun
    r0 = rises; i0 = inv_slots; fc0 = fc_pulses;
    for (int k = 1; k <= 5; k++) begin wr(W'(k)); sb.push_back(W'(k)); end
    @(negedge clk);
    check("a_fill", fill_level, 5);
    @(posedge clk); #1;
    do_start(5);
    wait_idle("a");
    check("a_rises", rises - r0, 5);
    check("a_invalid", inv_slots - i0, 0);
    check("a_complete", fc_pulses - fc0, 1);
    check("a_underrun", underrun, 0);
    check("a_fill_after", fill_level, 0);
    check("a_sb_empty", sb.size(), 0);

    // B: underrun slots while the host is late
    r0 = rises; i0 = inv_slots;
    wr(16'd10); sb.push_back(16'd10);
    wr(16'd20); sb.push_back(16'd20);
    do_start(4);
    repeat (30) @(posedge clk);
    #1;
    wr(16'd30); sb.push_back(16'd30);
    wr(16'd40); sb.push_back(16'd40);
    wait_idle("b");
    check("b_rises", rises - r0, 4);
    check("b_invalid", inv_slots - i0, 2);
    check("b_underrun", underrun, 1);
    check("b_sb_empty", sb.size(), 0);

    // C: overfill, 17th word dropped
    for (int k = 1; k <= 16; k++) begin wr(W'(k)); sb.push_back(W'(k)); end
    @(negedge clk);
    check("c_full16", wr_full, 1);
    @(posedge clk); #1;
    wr(16'd17);
    @(negedge clk);
    check("c_fill", fill_level, 16);
    check("c_full", wr_full, 1);
    @(posedge clk); #1;
    r0 = rises;
    do_start(16);
    wait_idle("c");
    check("c_rises", rises - r0, 16);
    check("c_underrun", underrun, 0);
    check("c_sb_empty", sb.size(), 0);
    check("c_fill_after", fill_level, 0);

    // D: zero-length feed
    r0 = rises; i0 = inv_slots; fr0 = fr_pulses; fc0 = fc_pulses;
    @(posedge clk); #1;
    do_start(0);
    wait_idle("d");
    check("d_rises", (rises - r0) + (inv_slots - i0), 0);
    check("d_reset_pulses", fr_pulses - fr0, 1);
    check("d_complete_pulses", fc_pulses - fc0, 1);

    // E: second start ignored, reset at third sample aborts
    for (int k = 1; k <= 10; k++) begin wr(W'(k)); sb.push_back(W'(k)); end
    do_start(10);
    fr0 = fr_pulses + 1;
    n = 0;
    while (rises_in_feed < 1 && n < 100) begin @(negedge clk); n++; end
    check("e_first_rise", rises_in_feed >= 1, 1);
    @(posedge clk); #1;
    do_start(1);
    fc0 = fc_pulses;
    n = 0;
    while (!(sample_valid && data == 16'd3) && n < 200) begin @(negedge clk); n++; end
    check("e_third_sample", data, 3);
    check("e_second_start_ignored", fr_pulses, fr0);
    check("e_busy_mid", busy, 1);
    reset_n = 1'b0;
    wr_en = 1'b1;
    wr_data = 16'd99;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("e_abort");
    @(negedge clk);
    check("e_wr_ignored", fill_level, 0);
    wr_en = 1'b0;
    reset_n = 1'b1;
    sb.delete();
    repeat (20) @(negedge clk);
    check("e_no_complete", fc_pulses, fc0);
    check("e_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
